ldm_stm_sequencer: RTL and testbench
====================================

Name: ldm_stm_sequencer

Overview:
- Multi-register transfer sequencer for the Cortex-M0 core, covering PUSH, POP, LDMIA and STMIA.
- Takes a decoded register list and walks it one register per memory beat, driving the register file directly through read ports 0/1 and write ports 1/2.
- Issues word accesses to the data-memory interface and performs the base-register writeback.
- Sits between the decoder/control unit and the register file/memory interface; the control unit stalls while BUSY is high.

Parameters:
- LIST_W, 9, register-list width: bits 7:0 = R0..R7, bit 8 = LR (stores) or PC (loads).
- HI_IDX, 14, register-file index that list bit 8 maps to on stores.

Ports:
- CLK  input  1  clock.
- nRST  input  1  synchronous reset, active low.
- START  input  1  one-cycle request pulse, sampled only in IDLE.
- LOAD  input  1  1 = load (LDM/POP), 0 = store (STM/PUSH).
- DECB  input  1  1 = decrement-before (PUSH), 0 = increment-after.
- WBACK  input  1  base writeback requested.
- RN  input  4  base register index.
- REGLIST  input  LIST_W  register list.
- RF_RA0  output  4  base read address.
- RF_DOUT0  input  32  base value.
- RF_RA1  output  4  store-data read address.
- RF_DOUT1  input  32  store data.
- RF_WEN1/RF_WA1/RF_DI1  output  1/4/32  load-data write port.
- RF_WEN2/RF_WA2/RF_DI2  output  1/4/32  base-writeback port.
- MEM_REQ  output  1  access request.
- MEM_WR  output  1  1 = write.
- MEM_ADDR  output  32  word address.
- MEM_WDATA  output  32  write data.
- MEM_READY  input  1  access complete this cycle.
- MEM_RDATA  input  32  read data, valid with MEM_READY.
- PC_WEN  output  1  load of PC (list bit 8 on loads).
- PC_DATA  output  32  loaded PC value.
- BUSY  output  1  sequencer active.
- DONE  output  1  one-cycle completion pulse.

Behaviour:
- Reset: nRST low at a CLK edge forces IDLE regardless of state. All outputs are 0 in the following cycle, including MEM_REQ, BUSY, DONE, and all WEN/PC_WEN. An in-flight access is abandoned and no writeback occurs.
- States and transitions:
  - IDLE: START=1 with REGLIST!=0 goes to SETUP. START=1 with REGLIST==0 goes to FIN (no access). START is ignored outside IDLE.
  - SETUP, 1 cycle:
    - RF_RA0=RN; RF_DOUT0 latched as base.
    - N = popcount(REGLIST), range 1..9.
    - Start address = DECB ? base-4N : base.
    - Final base = DECB ? base-4N : base+4N.
    - MEM_ADDR[1:0] is always 00.
  - XFER:
    - Each beat: MEM_REQ=1, MEM_WR=~LOAD, MEM_ADDR held stable until MEM_READY.
    - Registers go in ascending index order at ascending addresses.
    - Store: RF_RA1 = current register (bit 8 maps to HI_IDX); MEM_WDATA = RF_DOUT1 combinationally.
    - Load: in the MEM_READY cycle, RF_WEN1=1, RF_WA1 = current index, RF_DI1 = MEM_RDATA.
    - Load with bit 8: PC_WEN=1 and PC_DATA=MEM_RDATA instead; no RF write.
    - MEM_READY advances to the next set bit and adds 4 to the address. MEM_READY on the last beat goes to FIN.
    - MEM_READY is ignored when MEM_REQ=0.
  - FIN, 1 cycle:
    - DONE=1.
    - If WBACK=1 and not (LOAD=1 and REGLIST[RN]=1 with RN<8): RF_WEN2=1, RF_WA2=RN, RF_DI2 = final base. Otherwise no writeback; the loaded value wins.
    - Next state is IDLE.
- BUSY = 1 in SETUP, XFER and FIN.
- Latency with zero-wait memory: START at cycle t, SETUP at t+1, beats at t+2..t+1+N, FIN/DONE at t+2+N. Each wait cycle adds 1.
- Address arithmetic is 32-bit modulo 2^32. Wrap-around is allowed and not flagged.
- RF_WEN1 and RF_WEN2 are never asserted in the same cycle.
- Operation inputs (LOAD, DECB, WBACK, RN, REGLIST) are captured at START. Later changes have no effect.

Test Plan:
- PUSH {R4,LR}: LOAD=0, DECB=1, WBACK=1, RN=13, SP=0x00010000, zero wait. Required: writes R4 to 0x0000FFF8 and R14 to 0x0000FFFC; RF_WEN2 writes R13=0x0000FFF8 with DONE at t+4.
- POP {R0,R1,PC}: LOAD=1, DECB=0, SP=0x0000FFF4, memory {1,2,0x100}. Required: R0=1, R1=2, PC_WEN with 0x100, SP=0x00010000.
- LDMIA R2!,{R1,R2}: base 0x2000. Required: R1 and R2 loaded from 0x2000/0x2004; no RF_WEN2.
- STMIA with 2 MEM_READY wait cycles per beat: MEM_ADDR/MEM_WDATA stable while waiting; DONE at t+2+3N.
- nRST low during the second beat of a 4-register store: next cycle MEM_REQ=0, BUSY=0, no writeback. A new START then runs normally.
- START with REGLIST=0: no MEM_REQ; DONE at t+1 with WBACK writeback of the unchanged base.

Source files
------------

// File: rtl/ldm_stm_sequencer.sv
// Multi-register load/store sequencer (PUSH/POP/LDMIA/STMIA): walks a register list
// one word beat at a time, driving the register file and data-memory ports directly.
module ldm_stm_sequencer #(
  parameter int LIST_W = 9,
  parameter int HI_IDX = 14
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              START,
  input  logic              LOAD,
  input  logic              DECB,
  input  logic              WBACK,
  input  logic [3:0]        RN,
  input  logic [LIST_W-1:0] REGLIST,
  output logic [3:0]        RF_RA0,
  input  logic [31:0]       RF_DOUT0,
  output logic [3:0]        RF_RA1,
  input  logic [31:0]       RF_DOUT1,
  output logic              RF_WEN1,
  output logic [3:0]        RF_WA1,
  output logic [31:0]       RF_DI1,
  output logic              RF_WEN2,
  output logic [3:0]        RF_WA2,
  output logic [31:0]       RF_DI2,
  output logic              MEM_REQ,
  output logic              MEM_WR,
  output logic [31:0]       MEM_ADDR,
  output logic [31:0]       MEM_WDATA,
  input  logic              MEM_READY,
  input  logic [31:0]       MEM_RDATA,
  output logic              PC_WEN,
  output logic [31:0]       PC_DATA,
  output logic              BUSY,
  output logic              DONE
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SETUP = 2'd1;
  localparam logic [1:0] S_XFER  = 2'd2;
  localparam logic [1:0] S_FIN   = 2'd3;

  localparam logic [3:0] HI_REG = 4'(HI_IDX);
  localparam logic [3:0] HI_BIT = 4'(LIST_W - 1);

  logic [1:0]        state_q, state_d;
  logic              load_q, load_d;
  logic              decb_q, decb_d;
  logic              wback_q, wback_d;
  logic [3:0]        rn_q, rn_d;
  logic [LIST_W-1:0] list_q, list_d;
  logic [LIST_W-1:0] rem_q, rem_d;
  logic [31:0]       addr_q, addr_d;
  logic [31:0]       final_q, final_d;

  logic [3:0]        cur_bit;
  logic [3:0]        cnt;
  logic [31:0]       span;
  logic [LIST_W-1:0] rem_clr;
  logic              is_hi;
  logic              list_empty;
  logic              wb_block;

  // Lowest remaining list bit is the register for the current beat.
  always_comb begin
    cur_bit = 4'd0;
    for (int i = LIST_W - 1; i >= 0; i--) begin
      if (rem_q[i]) cur_bit = 4'(i);
    end
  end

  always_comb begin
    cnt = 4'd0;
    for (int i = 0; i < LIST_W; i++) begin
      cnt = cnt + {3'd0, list_q[i]};
    end
  end

  assign span       = {26'd0, cnt, 2'b00};
  assign rem_clr    = rem_q & (rem_q - {{(LIST_W-1){1'b0}}, 1'b1});
  assign is_hi      = (cur_bit == HI_BIT);
  assign list_empty = (list_q == '0);
  // A load that overwrites its own base keeps the loaded value.
  assign wb_block   = load_q && !rn_q[3] && list_q[rn_q[2:0]];

  always_comb begin
    state_d = state_q;
    load_d  = load_q;
    decb_d  = decb_q;
    wback_d = wback_q;
    rn_d    = rn_q;
    list_d  = list_q;
    rem_d   = rem_q;
    addr_d  = addr_q;
    final_d = final_q;
    case (state_q)
      S_IDLE: begin
        if (START) begin
          load_d  = LOAD;
          decb_d  = DECB;
          wback_d = WBACK;
          rn_d    = RN;
          list_d  = REGLIST;
          rem_d   = REGLIST;
          state_d = (REGLIST == '0) ? S_FIN : S_SETUP;
        end
      end
      S_SETUP: begin
        addr_d  = decb_q ? (RF_DOUT0 - span) : RF_DOUT0;
        final_d = decb_q ? (RF_DOUT0 - span) : (RF_DOUT0 + span);
        state_d = S_XFER;
      end
      S_XFER: begin
        if (MEM_READY) begin
          rem_d  = rem_clr;
          addr_d = addr_q + 32'd4;
          if (rem_clr == '0) state_d = S_FIN;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state_q <= S_IDLE;
      load_q  <= 1'b0;
      decb_q  <= 1'b0;
      wback_q <= 1'b0;
      rn_q    <= 4'd0;
      list_q  <= '0;
      rem_q   <= '0;
      addr_q  <= 32'd0;
      final_q <= 32'd0;
    end else begin
      state_q <= state_d;
      load_q  <= load_d;
      decb_q  <= decb_d;
      wback_q <= wback_d;
      rn_q    <= rn_d;
      list_q  <= list_d;
      rem_q   <= rem_d;
      addr_q  <= addr_d;
      final_q <= final_d;
    end
  end

  always_comb begin
    RF_RA0    = 4'd0;
    RF_RA1    = 4'd0;
    RF_WEN1   = 1'b0;
    RF_WA1    = 4'd0;
    RF_DI1    = 32'd0;
    RF_WEN2   = 1'b0;
    RF_WA2    = 4'd0;
    RF_DI2    = 32'd0;
    MEM_REQ   = 1'b0;
    MEM_WR    = 1'b0;
    MEM_ADDR  = 32'd0;
    MEM_WDATA = 32'd0;
    PC_WEN    = 1'b0;
    PC_DATA   = 32'd0;
    BUSY      = (state_q != S_IDLE);
    DONE      = (state_q == S_FIN);
    case (state_q)
      S_SETUP: RF_RA0 = rn_q;
      S_XFER: begin
        MEM_REQ  = 1'b1;
        MEM_WR   = !load_q;
        MEM_ADDR = {addr_q[31:2], 2'b00};
        if (!load_q) begin
          RF_RA1    = is_hi ? HI_REG : cur_bit;
          MEM_WDATA = RF_DOUT1;
        end else if (MEM_READY) begin
          if (is_hi) begin
            PC_WEN  = 1'b1;
            PC_DATA = MEM_RDATA;
          end else begin
            RF_WEN1 = 1'b1;
            RF_WA1  = cur_bit;
            RF_DI1  = MEM_RDATA;
          end
        end
      end
      S_FIN: begin
        // An empty list never passed through SETUP, so the base is read here.
        if (list_empty) RF_RA0 = rn_q;
        if (wback_q && !wb_block) begin
          RF_WEN2 = 1'b1;
          RF_WA2  = rn_q;
          RF_DI2  = list_empty ? RF_DOUT0 : final_q;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_ldm_stm_sequencer.sv
// Scoreboard bench for ldm_stm_sequencer: directed operations push expected events,
// a monitor pops and compares every observed memory beat, RF write, PC load and DONE.
module tb_ldm_stm_sequencer;

  localparam int K_WR   = 0;
  localparam int K_RD   = 1;
  localparam int K_LD   = 2;
  localparam int K_PC   = 3;
  localparam int K_WB   = 4;
  localparam int K_DONE = 5;

  typedef struct {
    int          kind;
    logic [31:0] a;
    logic [31:0] d;
  } ev_t;

  logic        CLK = 1'b0;
  logic        nRST, START, LOAD, DECB, WBACK;
  logic [3:0]  RN;
  logic [8:0]  REGLIST;
  logic [3:0]  RF_RA0, RF_RA1, RF_WA1, RF_WA2;
  logic [31:0] RF_DOUT0, RF_DOUT1, RF_DI1, RF_DI2;
  logic        RF_WEN1, RF_WEN2, MEM_REQ, MEM_WR, MEM_READY, PC_WEN, BUSY, DONE;
  logic [31:0] MEM_ADDR, MEM_WDATA, MEM_RDATA, PC_DATA;

  logic [31:0] rf [16];
  logic [31:0] mem [logic [31:0]];
  ev_t         exp_q [$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          t0 = 0;
  int          wait_cfg = 0;
  int          wcnt = 0;
  logic        stall_prev = 1'b0;
  logic [31:0] prev_addr, prev_wdata;

  ldm_stm_sequencer #(.LIST_W(9), .HI_IDX(14)) dut (
    .CLK(CLK), .nRST(nRST), .START(START), .LOAD(LOAD), .DECB(DECB), .WBACK(WBACK),
    .RN(RN), .REGLIST(REGLIST),
    .RF_RA0(RF_RA0), .RF_DOUT0(RF_DOUT0), .RF_RA1(RF_RA1), .RF_DOUT1(RF_DOUT1),
    .RF_WEN1(RF_WEN1), .RF_WA1(RF_WA1), .RF_DI1(RF_DI1),
    .RF_WEN2(RF_WEN2), .RF_WA2(RF_WA2), .RF_DI2(RF_DI2),
    .MEM_REQ(MEM_REQ), .MEM_WR(MEM_WR), .MEM_ADDR(MEM_ADDR), .MEM_WDATA(MEM_WDATA),
    .MEM_READY(MEM_READY), .MEM_RDATA(MEM_RDATA),
    .PC_WEN(PC_WEN), .PC_DATA(PC_DATA), .BUSY(BUSY), .DONE(DONE)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) cyc <= cyc + 1;

  assign RF_DOUT0 = rf[RF_RA0];
  assign RF_DOUT1 = rf[RF_RA1];

  // Memory model: ready after wait_cfg stall cycles per beat.
  always @(negedge CLK) begin
    if (MEM_REQ) begin
      if (wcnt >= wait_cfg) begin
        MEM_READY = 1'b1;
        wcnt = 0;
      end else begin
        MEM_READY = 1'b0;
        wcnt++;
      end
    end else begin
      MEM_READY = 1'b0;
      wcnt = 0;
    end
    MEM_RDATA = mem.exists(MEM_ADDR) ? mem[MEM_ADDR] : 32'hBAD0_0000;
  end

  function automatic string kname(input int k);
    case (k)
      K_WR:    return "mem_wr";
      K_RD:    return "mem_rd";
      K_LD:    return "rf_load";
      K_PC:    return "pc_load";
      K_WB:    return "base_wb";
      default: return "done_cyc";
    endcase
  endfunction

  task automatic expect_ev(input int k, input logic [31:0] a, input logic [31:0] d);
    ev_t e;
    e.kind = k;
    e.a = a;
    e.d = d;
    exp_q.push_back(e);
  endtask

  task automatic observe(input int k, input logic [31:0] a, input logic [31:0] d);
    ev_t e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL unexpected_%s: got a=%h d=%h, required no event", kname(k), a, d);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != k || e.a != a || e.d != d) begin
        errors++;
        $display("FAIL %s: got %s a=%h d=%h, required %s a=%h d=%h",
                 kname(e.kind), kname(k), a, d, kname(e.kind), e.a, e.d);
      end else begin
        $display("ok   %s a=%h d=%h", kname(k), a, d);
      end
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end else begin
      $display("ok   %s = %h", name, act);
    end
  endtask

  // Monitor: samples mid-cycle, after the memory model has updated READY/RDATA.
  always @(negedge CLK) begin
    #2;
    if (MEM_REQ) begin
      checks++;
      if (MEM_ADDR[1:0] != 2'b00) begin
        errors++;
        $display("FAIL addr_align: got %h, required low bits 00", MEM_ADDR);
      end
      if (stall_prev) begin
        checks++;
        if (MEM_ADDR != prev_addr || MEM_WDATA != prev_wdata) begin
          errors++;
          $display("FAIL hold_during_wait: got addr=%h wdata=%h, required addr=%h wdata=%h",
                   MEM_ADDR, MEM_WDATA, prev_addr, prev_wdata);
        end
      end
    end
    stall_prev = MEM_REQ && !MEM_READY;
    prev_addr  = MEM_ADDR;
    prev_wdata = MEM_WDATA;
    if (RF_WEN1 || RF_WEN2) begin
      checks++;
      if (RF_WEN1 && RF_WEN2) begin
        errors++;
        $display("FAIL wen_exclusive: got RF_WEN1=1 RF_WEN2=1, required at most one");
      end
    end
    if (MEM_REQ && MEM_READY) observe(MEM_WR ? K_WR : K_RD, MEM_ADDR, MEM_WR ? MEM_WDATA : 32'd0);
    if (RF_WEN1) observe(K_LD, {28'd0, RF_WA1}, RF_DI1);
    if (PC_WEN)  observe(K_PC, 32'd0, PC_DATA);
    if (RF_WEN2) observe(K_WB, {28'd0, RF_WA2}, RF_DI2);
    if (DONE)    observe(K_DONE, 32'd0, 32'(cyc - t0));
  end

  task automatic run_op(input logic ld, input logic dec, input logic wb,
                        input logic [3:0] rn, input logic [8:0] list);
    bit fin = 1'b0;
    @(negedge CLK);
    t0 = cyc;
    LOAD = ld; DECB = dec; WBACK = wb; RN = rn; REGLIST = list; START = 1'b1;
    @(negedge CLK);
    // Scramble operands: the captured copies must be used.
    START = 1'b0; LOAD = ~ld; DECB = ~dec; WBACK = ~wb; RN = rn + 4'd3; REGLIST = ~list;
    for (int i = 0; i < 300; i++) begin
      #3;
      if (!BUSY) begin
        fin = 1'b1;
        break;
      end
      @(negedge CLK);
    end
    checks++;
    if (!fin) begin
      errors++;
      $display("FAIL op_timeout: got BUSY=1 after 300 cycles, required BUSY=0");
    end
    LOAD = 1'b0; DECB = 1'b0; WBACK = 1'b0; RN = 4'd0; REGLIST = 9'd0;
  endtask

  initial begin
    nRST = 1'b0; START = 1'b0; LOAD = 1'b0; DECB = 1'b0; WBACK = 1'b0;
    RN = 4'd0; REGLIST = 9'd0; MEM_READY = 1'b0; MEM_RDATA = 32'd0;
    for (int i = 0; i < 16; i++) rf[i] = 32'h1000_0000 + 32'(i);

    repeat (3) @(negedge CLK);
    #3;
    chk("rst_mem_req", {31'd0, MEM_REQ}, 32'd0);
    chk("rst_mem_wr",  {31'd0, MEM_WR},  32'd0);
    chk("rst_busy",    {31'd0, BUSY},    32'd0);
    chk("rst_done",    {31'd0, DONE},    32'd0);
    chk("rst_wen1",    {31'd0, RF_WEN1}, 32'd0);
    chk("rst_wen2",    {31'd0, RF_WEN2}, 32'd0);
    chk("rst_pc_wen",  {31'd0, PC_WEN},  32'd0);
    chk("rst_addr",    MEM_ADDR,         32'd0);
    @(negedge CLK);
    nRST = 1'b1;

    // PUSH {R4,LR}, SP=0x10000
    rf[13] = 32'h0001_0000; rf[4] = 32'h4444_0004; rf[14] = 32'hEEEE_000E;
    expect_ev(K_WR, 32'h0000_FFF8, 32'h4444_0004);
    expect_ev(K_WR, 32'h0000_FFFC, 32'hEEEE_000E);
    expect_ev(K_WB, 32'd13, 32'h0000_FFF8);
    expect_ev(K_DONE, 32'd0, 32'd4);
    run_op(1'b0, 1'b1, 1'b1, 4'd13, 9'h110);

    // POP {R0,R1,PC}, SP=0xFFF4
    rf[13] = 32'h0000_FFF4;
    mem[32'h0000_FFF4] = 32'd1; mem[32'h0000_FFF8] = 32'd2; mem[32'h0000_FFFC] = 32'h100;
    expect_ev(K_RD, 32'h0000_FFF4, 32'd0);
    expect_ev(K_LD, 32'd0, 32'd1);
    expect_ev(K_RD, 32'h0000_FFF8, 32'd0);
    expect_ev(K_LD, 32'd1, 32'd2);
    expect_ev(K_RD, 32'h0000_FFFC, 32'd0);
    expect_ev(K_PC, 32'd0, 32'h100);
    expect_ev(K_WB, 32'd13, 32'h0001_0000);
    expect_ev(K_DONE, 32'd0, 32'd5);
    run_op(1'b1, 1'b0, 1'b1, 4'd13, 9'h103);

    // LDMIA R2!,{R1,R2}: base in list, writeback suppressed
    rf[2] = 32'h0000_2000;
    mem[32'h0000_2000] = 32'h0000_00A1; mem[32'h0000_2004] = 32'h0000_00A2;
    expect_ev(K_RD, 32'h0000_2000, 32'd0);
    expect_ev(K_LD, 32'd1, 32'h0000_00A1);
    expect_ev(K_RD, 32'h0000_2004, 32'd0);
    expect_ev(K_LD, 32'd2, 32'h0000_00A2);
    expect_ev(K_DONE, 32'd0, 32'd4);
    run_op(1'b1, 1'b0, 1'b1, 4'd2, 9'h006);

    // STMIA R0!,{R1,R3,R5} with two wait cycles per beat
    wait_cfg = 2;
    rf[0] = 32'h0000_3000; rf[1] = 32'h11; rf[3] = 32'h33; rf[5] = 32'h55;
    expect_ev(K_WR, 32'h0000_3000, 32'h11);
    expect_ev(K_WR, 32'h0000_3004, 32'h33);
    expect_ev(K_WR, 32'h0000_3008, 32'h55);
    expect_ev(K_WB, 32'd0, 32'h0000_300C);
    expect_ev(K_DONE, 32'd0, 32'd11);
    run_op(1'b0, 1'b0, 1'b1, 4'd0, 9'h02A);
    wait_cfg = 0;

    // Reset during second beat of a 4-register store
    rf[13] = 32'h0000_4000;
    for (int i = 0; i < 4; i++) rf[i] = 32'hC0DE_0000 + 32'(i);
    expect_ev(K_WR, 32'h0000_4000, 32'hC0DE_0000);
    expect_ev(K_WR, 32'h0000_4004, 32'hC0DE_0001);
    @(negedge CLK);
    t0 = cyc;
    LOAD = 1'b0; DECB = 1'b0; WBACK = 1'b1; RN = 4'd13; REGLIST = 9'h00F; START = 1'b1;
    @(negedge CLK);
    START = 1'b0;
    @(negedge CLK);
    @(negedge CLK);
    nRST = 1'b0;
    @(negedge CLK);
    #3;
    chk("abort_mem_req", {31'd0, MEM_REQ}, 32'd0);
    chk("abort_busy",    {31'd0, BUSY},    32'd0);
    chk("abort_wen2",    {31'd0, RF_WEN2}, 32'd0);
    chk("abort_done",    {31'd0, DONE},    32'd0);
    nRST = 1'b1;
    repeat (2) @(negedge CLK);

    // Empty list: no access, DONE next cycle, unchanged base written back
    rf[5] = 32'h5555_0000;
    expect_ev(K_WB, 32'd5, 32'h5555_0000);
    expect_ev(K_DONE, 32'd0, 32'd1);
    run_op(1'b0, 1'b0, 1'b1, 4'd5, 9'h000);

    // PUSH {R0,R1} with SP=4: address wraps through zero
    rf[13] = 32'h0000_0004; rf[0] = 32'hA0; rf[1] = 32'hA1;
    expect_ev(K_WR, 32'hFFFF_FFFC, 32'hA0);
    expect_ev(K_WR, 32'h0000_0000, 32'hA1);
    expect_ev(K_WB, 32'd13, 32'hFFFF_FFFC);
    expect_ev(K_DONE, 32'd0, 32'd4);
    run_op(1'b0, 1'b1, 1'b1, 4'd13, 9'h003);

    repeat (5) @(negedge CLK);
    #3;
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
